// File: rtl/axis_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_pkg : shared AXI4-Stream widths, buffering modes and beat-width helper
// Rev 1.0
// ----------------------------------------------------------------------------
package axis_pkg;

   localparam int AXIS_TDATA_WIDTH = 32;
   localparam int AXIS_TID_WIDTH   = 8;
   localparam int AXIS_TDEST_WIDTH = 8;
   localparam int AXIS_TUSER_WIDTH = 8;
   localparam int AXIS_DEPTH       = 16;

   typedef enum logic {
      AXIS_CUT_THROUGH = 1'b0,
      AXIS_STORE_FWD   = 1'b1
   } axis_mode_e;

   // Packed beat: {twakeup, tlast, tuser, tdest, tid, tstrb, tkeep, tdata}
   function automatic int axis_beat_width(input int dw, input int iw, input int dsw, input int uw);
      return dw + 2 * (dw / 8) + iw + dsw + uw + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_fifo_ctrl : wrap-bit read/write pointers, full/empty flags and fill level
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_fifo_ctrl #(
   parameter int DEPTH = 16
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     push,
   input  logic                     pop,
   output logic [$clog2(DEPTH)-1:0] wr_addr,
   output logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Extra MSB distinguishes full from empty when the address bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign wr_addr = wr_ptr[AW-1:0];
   assign rd_addr = rd_ptr[AW-1:0];

endmodule
`default_nettype wire

// File: rtl/axis_pipe_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_pipe_fifo : AXI4-Stream FIFO buffer, cut-through or store-and-forward
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_pipe_fifo
   import axis_pkg::*;
#(
   parameter int         TDATA_WIDTH = AXIS_TDATA_WIDTH,
   parameter int         TID_WIDTH   = AXIS_TID_WIDTH,
   parameter int         TDEST_WIDTH = AXIS_TDEST_WIDTH,
   parameter int         TUSER_WIDTH = AXIS_TUSER_WIDTH,
   parameter int         DEPTH       = AXIS_DEPTH,
   parameter axis_mode_e PACKET_MODE = AXIS_CUT_THROUGH
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [TDATA_WIDTH/8-1:0]   s_axis_tstrb,
   input  logic [TID_WIDTH-1:0]       s_axis_tid,
   input  logic [TDEST_WIDTH-1:0]     s_axis_tdest,
   input  logic [TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_twakeup,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [TDATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic [TID_WIDTH-1:0]       m_axis_tid,
   output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
   output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                       m_axis_tlast,
   output logic                       m_axis_twakeup,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf_release
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = axis_beat_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);

   logic [BW-1:0] mem [DEPTH];
   logic [BW-1:0] wr_beat;
   logic [BW-1:0] rd_beat;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          push_last;
   logic          pop_last;
   logic          head_ready;
   logic [LW-1:0] pkt_cnt;
   logic          rel_q;

   axis_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .aclk    (aclk),
      .areset  (areset),
      .push    (push),
      .pop     (pop),
      .wr_addr (wr_addr),
      .rd_addr (rd_addr),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign s_axis_tready = !full && !areset;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign push_last     = push && s_axis_tlast;
   assign pop_last      = pop && m_axis_tlast;

   assign wr_beat = {s_axis_twakeup, s_axis_tlast, s_axis_tuser, s_axis_tdest,
                     s_axis_tid, s_axis_tstrb, s_axis_tkeep, s_axis_tdata};

   always_ff @(posedge aclk) begin
      if (push) mem[wr_addr] <= wr_beat;
   end

   // Store-and-forward holds the head back until a whole packet is stored,
   // unless an overlong packet has filled the buffer and forced a release.
   always_comb begin
      head_ready = 1'b1;
      if (PACKET_MODE == AXIS_STORE_FWD) head_ready = (pkt_cnt != '0) || rel_q;
   end

   assign m_axis_tvalid = !empty && head_ready && !areset;
   assign rd_beat       = m_axis_tvalid ? mem[rd_addr] : '0;

   assign {m_axis_twakeup, m_axis_tlast, m_axis_tuser, m_axis_tdest,
           m_axis_tid, m_axis_tstrb, m_axis_tkeep, m_axis_tdata} = rd_beat;

   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_cnt     <= '0;
         rel_q       <= 1'b0;
         ovf_release <= 1'b0;
      end else begin
         if (push_last && !pop_last)      pkt_cnt <= pkt_cnt + 1'b1;
         else if (pop_last && !push_last) pkt_cnt <= pkt_cnt - 1'b1;

         ovf_release <= 1'b0;
         if (pop_last) begin
            rel_q <= 1'b0;
         end else if ((PACKET_MODE == AXIS_STORE_FWD) && full && (pkt_cnt == '0) && !rel_q) begin
            rel_q       <= 1'b1;
            ovf_release <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
